morse_press_timer: RTL
======================

// Module: morse_press_timer
// PURPOSE
//  Parametrised successor to the 2-bit saturating press counter. Measures key-down and
//  key-up durations in timebase ticks, classifies each press as dot or dash, and flags
//  letter and word gaps. Sits between the debounced key input and the symbol shift/decode logic.
// PARAMETERS
//  WIDTH        8  counter width; count saturates at 2^WIDTH-1
//  DASH_THRESH  3  press of >= DASH_THRESH ticks is a dash, fewer is a dot
//  LETTER_GAP   3  key-up ticks that end a letter
//  WORD_GAP     7  key-up ticks that end a word; 1 <= LETTER_GAP < WORD_GAP <= 2^WIDTH-1
// PORTS
//  CLK         in   1      system clock, rising edge
//  RST         in   1      asynchronous, active-high reset
//  tick_en     in   1      one-cycle timebase strobe (one Morse unit)
//  key_in      in   1      synchronised, debounced key level (1 = pressed)
//  count       out  WIDTH  current press or gap tick count
//  pressing    out  1      1 while state == PRESS
//  saturated   out  1      count == 2^WIDTH-1
//  sym_valid   out  1      one-cycle pulse: a press has ended
//  sym_dash    out  1      qualifies sym_valid: 1 = dash, 0 = dot; holds until next sym_valid
//  letter_end  out  1      one-cycle pulse: gap reached LETTER_GAP
//  word_end    out  1      one-cycle pulse: gap reached WORD_GAP
// BEHAVIOUR
//  - One clock (CLK). Reset is asynchronous and active-high (RST).
//  - On RST: state = IDLE; count, sym_dash and all pulses = 0; pressing = 0, saturated = 0.
//  - All outputs are registered. A pulse is asserted in the cycle after the clock edge
//    that sampled its cause, and is held for exactly one cycle.
//  - States: IDLE (count held at 0), PRESS, GAP.
//  - IDLE: key_in=1 -> PRESS, count<=0. tick_en is ignored.
//  - PRESS, key_in=1: on tick_en, count <= count+1, saturating at 2^WIDTH-1 (no wrap).
//  - PRESS, key_in=0 -> GAP, count<=0; sym_valid<=1; sym_dash <= (count >= DASH_THRESH).
//    The comparison uses count before this edge; a tick on the same cycle is dropped.
//  - GAP, key_in=1 -> PRESS, count<=0, no gap pulse. This is an intra-letter gap.
//  - GAP, key_in=0, tick_en: count<=count+1 (saturating).
//      count+1 == LETTER_GAP -> letter_end<=1 (once per gap).
//      count+1 == WORD_GAP   -> word_end<=1, state -> IDLE, count<=0.
//  - Key edges take priority over tick_en in the same cycle.
//  - A press of 0 ticks (released before any tick) is still reported, as a dot.
//  - saturated is combinational-free: it is registered alongside count.
//  - Reset mid-press or mid-gap aborts with no pulses. If key_in=1 after reset release,
//    the block enters PRESS on the next edge and times a fresh press.
//  - sym_valid and letter_end never assert in the same cycle.
// TESTING (defaults unless stated; ticks every 4 cycles)
//  1. Key high 1 tick, then low -> sym_valid=1, sym_dash=0 one cycle after the fall;
//     count returns to 0.
//  2. Key high 4 ticks, then low -> sym_valid=1, sym_dash=1; later key low 3 ticks ->
//     letter_end pulse at the 3rd tick, word_end at the 7th tick, state IDLE, count=0.
//  3. Dot, gap of 2 ticks, dot -> two sym_valid pulses, no letter_end or word_end between.
//  4. WIDTH=3, key high 10 ticks -> count stops at 7, saturated=1; on release sym_dash=1,
//     saturated clears.
//  5. Key fall on the same cycle as tick_en at count=2 -> sym_dash=0 (the tick is dropped).
//  6. Assert RST at count=5 during PRESS while key stays high -> all outputs 0 at once,
//     no sym_valid; after release, PRESS is re-entered with count=0.

Source files
------------

// File: rtl/morse_press_timer.sv
// Morse key timer: measures press and gap lengths in timebase ticks, reports each
// press as dot/dash and pulses on letter and word gaps.
module morse_press_timer #(
  parameter int WIDTH       = 8,
  parameter int DASH_THRESH = 3,
  parameter int LETTER_GAP  = 3,
  parameter int WORD_GAP    = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick_en,
  input  logic             key_in,
  output logic [WIDTH-1:0] count,
  output logic             pressing,
  output logic             saturated,
  output logic             sym_valid,
  output logic             sym_dash,
  output logic             letter_end,
  output logic             word_end
);

  localparam logic [WIDTH-1:0] CMAX     = '1;
  localparam logic [WIDTH:0]   DASH_T   = DASH_THRESH[WIDTH:0];
  localparam logic [WIDTH-1:0] LETTER_T = LETTER_GAP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] WORD_T   = WORD_GAP[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx, count_inc;
  logic             sym_valid_nx, sym_dash_nx, letter_nx, word_nx;

  assign count_inc = (count == CMAX) ? count : count + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      count      <= '0;
      pressing   <= 1'b0;
      saturated  <= 1'b0;
      sym_valid  <= 1'b0;
      sym_dash   <= 1'b0;
      letter_end <= 1'b0;
      word_end   <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      pressing   <= (state_nx == PRESS);
      saturated  <= (count_nx == CMAX);
      sym_valid  <= sym_valid_nx;
      sym_dash   <= sym_dash_nx;
      letter_end <= letter_nx;
      word_end   <= word_nx;
    end
  end

  // Key edges win over tick_en: a tick on the edge cycle is dropped.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    sym_valid_nx = 1'b0;
    sym_dash_nx  = sym_dash;
    letter_nx    = 1'b0;
    word_nx      = 1'b0;
    case (state)
      IDLE: begin
        count_nx = '0;
        if (key_in) state_nx = PRESS;
      end
      PRESS: begin
        if (!key_in) begin
          state_nx     = GAP;
          count_nx     = '0;
          sym_valid_nx = 1'b1;
          sym_dash_nx  = ({1'b0, count} >= DASH_T);
        end else if (tick_en) begin
          count_nx = count_inc;
        end
      end
      GAP: begin
        if (key_in) begin
          state_nx = PRESS;
          count_nx = '0;
        end else if (tick_en) begin
          count_nx = count_inc;
          if (count_inc == LETTER_T) letter_nx = 1'b1;
          if (count_inc == WORD_T) begin
            word_nx  = 1'b1;
            state_nx = IDLE;
            count_nx = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

endmodule
